// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and stall sequencer for the 5-stage RISC-V pipeline. It sits
//   beside decode and generates hold/bubble controls for the PC, IF/ID and
//   ID/EX registers. It handles three cases:
//     - load-use hazards: a 1-cycle stall plus an ID/EX bubble
//     - taken-branch squash: flushes IF/ID and ID/EX
//     - multi-cycle EX ops (mul/div): a start/done handshake with a timeout
//
// Parameters
//   MC_TIMEOUT : maximum number of MC_WAIT cycles before the op is aborted
//                (legal range 2..65535)
//   CNT_W      : width of the wait counter and of the statistics counters
//
// Optional feature
//   Define HAZARD_STATS_EN to build the stall_cycles and flush_events
//   counters. When it is undefined, both ports are tied to 0 and no counter
//   flops exist.
//
// Ports
//   clk, reset        : rising-edge clock; asynchronous active-low reset
//   id_*              : decode-stage instruction (valid, sources, usage)
//   ex_*              : execute-stage instruction (valid, rd, load, taken
//                       branch, multi-cycle start)
//   mc_done           : 1-cycle result-valid pulse from the multi-cycle unit
//   pc_stall, if_id_stall, id_ex_stall : hold the corresponding register
//   if_id_flush, id_ex_flush           : load a NOP/bubble
//   mc_busy           : high while waiting on the multi-cycle unit
//   mc_timeout        : sticky abort flag, cleared only by reset
//   stall_cycles, flush_events         : saturating statistics
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             mc_busy,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [0:0] {RUN = 1'b0, MC_WAIT = 1'b1} state_t;

  // Last counter value that is still waiting; reaching it without done aborts.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MC_TIMEOUT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             to_set;
  logic             load_use;
  logic             to_hit;

  // Raw controls, before the reset gate.
  logic pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic id_ex_stall_c, id_ex_flush_c, mc_busy_c;

  // The ID instruction reads a register that the load in EX has not
  // produced yet. x0 is hardwired to zero, so it never hazards.
  assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // A done pulse on the last allowed cycle still counts as success.
  assign to_hit = (cnt == TO_LAST) & ~mc_done;

  // -------------------------------------------------------------------------
  // State, wait counter and sticky timeout flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      cnt        <= '0;
      mc_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (cnt_clr)
        cnt <= '0;
      else if (state == MC_WAIT && cnt != '1)
        cnt <= cnt + CNT_W'(1);
      if (to_set)
        mc_timeout <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and combinational controls
  // -------------------------------------------------------------------------
  always_comb begin
    state_n       = state;
    cnt_clr       = 1'b0;
    to_set        = 1'b0;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_stall_c = 1'b0;
    id_ex_flush_c = 1'b0;
    mc_busy_c     = 1'b0;
    case (state)
      RUN: begin
        if (ex_valid & ex_branch_taken) begin
          // The ID instruction is squashed, so its hazards and any
          // multi-cycle start in EX are moot.
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end else if (ex_valid & ex_mc_start) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_stall_c = 1'b1;
          cnt_clr       = 1'b1;
          state_n       = MC_WAIT;
        end else if (load_use) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end
      end
      MC_WAIT: begin
        // EX is frozen here, so the branch and load-use inputs are ignored.
        mc_busy_c = 1'b1;
        if (mc_done) begin
          // The stall is released and the result advances on this edge.
          state_n = RUN;
        end else if (to_hit) begin
          // Abort: the stuck op leaves EX as a bubble.
          id_ex_flush_c = 1'b1;
          to_set        = 1'b1;
          state_n       = RUN;
        end else begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_stall_c = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // Gate the controls with reset so the pipeline sees no stall or flush
  // while the core is held in reset, whatever the ID/EX inputs show.
  assign pc_stall    = pc_stall_c    & reset;
  assign if_id_stall = if_id_stall_c & reset;
  assign if_id_flush = if_id_flush_c & reset;
  assign id_ex_stall = id_ex_stall_c & reset;
  assign id_ex_flush = id_ex_flush_c & reset;
  assign mc_busy     = mc_busy_c     & reset;

  // -------------------------------------------------------------------------
  // Optional statistics
  // -------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((if_id_flush | id_ex_flush) && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_events = flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
